// File: rtl/cache_types.sv
// Shared cache-side types: adaptor FSM states and a counter sizing helper.
package cache_types;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

    // Counter width for n beats; never narrower than one bit so a
    // single-beat configuration still elaborates.
    function automatic int unsigned counter_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one line-wide cache request (fill or writeback) into a burst of
// s_line/s_burst beats on the memory bus, one transaction at a time.
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int unsigned s_line  = 256,
    parameter int unsigned s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [31:0]        address_i,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,

    output logic [31:0]        address_o,
    output logic [s_burst-1:0] burst_o,
    input  logic [s_burst-1:0] burst_i,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned s_offset = $clog2(s_line) - 3;
    localparam int unsigned beats    = s_line / s_burst;
    localparam int unsigned cnt_w    = counter_width(beats);

    localparam logic [cnt_w-1:0] last_beat   = cnt_w'(beats - 1);
    localparam logic [31:0]      offset_mask = ~((32'd1 << s_offset) - 32'd1);

    adaptor_state_t    state;
    adaptor_state_t    state_next;
    logic [cnt_w-1:0]  cnt;
    logic [s_line-1:0] buffer;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; request/response strobes decode directly from state
    always_comb begin
        state_next = state;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WR_BURST;
                end else if (read_i) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (resp_i && cnt == last_beat) begin
                    state_next = DONE;
                end
            end
            WR_BURST: begin
                write_o = 1'b1;
                if (resp_i && cnt == last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                resp_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching, beat counting and fill-line assembly
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            buffer    <= '0;
            address_o <= '0;
            line_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i || read_i) begin
                        address_o <= address_i & offset_mask;
                        cnt       <= '0;
                        if (write_i) begin
                            buffer <= line_i;
                        end
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_o[int'(cnt)*s_burst +: s_burst] <= burst_i;
                        cnt <= (cnt == last_beat) ? '0 : cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt <= (cnt == last_beat) ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outgoing write beat selected by the current beat index
    always_comb begin
        burst_o = buffer[int'(cnt)*s_burst +: s_burst];
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor: a behavioural cache/memory pair
// drives transactions and checks every beat, strobe and returned line.
module tb_cacheline_adaptor;

    localparam int unsigned LINE  = 256;
    localparam int unsigned BURST = 64;
    localparam int unsigned BEATS = LINE / BURST;
    localparam int unsigned OFF   = $clog2(LINE) - 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      address_i;
    logic [LINE-1:0]  line_i;
    logic [LINE-1:0]  line_o;
    logic             read_i;
    logic             write_i;
    logic             resp_o;
    logic [31:0]      address_o;
    logic [BURST-1:0] burst_o;
    logic [BURST-1:0] burst_i;
    logic             read_o;
    logic             write_o;
    logic             resp_i;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Last completed fill line; line_o must keep it until the next fill.
    logic [LINE-1:0] last_fill = '0;

    cacheline_adaptor #(
        .s_line (LINE),
        .s_burst(BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address_i(address_i),
        .line_i   (line_i),
        .line_o   (line_o),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .address_o(address_o),
        .burst_o  (burst_o),
        .burst_i  (burst_i),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & ~((32'd1 << OFF) - 32'd1);
    endfunction

    function automatic logic [LINE-1:0] rand_line();
        logic [LINE-1:0] l;
        for (int unsigned i = 0; i < LINE / 32; i++) begin
            l[i*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    // One cache transaction. Entered and left at a negedge in an idle cycle.
    // plen > 0 replays pattern[0..plen-1] as the memory strobe, else random.
    task automatic run_txn(input bit do_write, input bit do_read, input logic [31:0] addr,
                           input logic [LINE-1:0] wline, input logic [15:0] pattern,
                           input int unsigned plen, input bit directed);
        logic [LINE-1:0] exp_line;
        int unsigned     got_beats = 0;
        int unsigned     cyc = 0;
        bit              r;
        exp_line = last_fill;

        check("idle_read_o", read_o, 1'b0);
        check("idle_write_o", write_o, 1'b0);
        address_i = addr;
        line_i    = wline;
        write_i   = do_write;
        read_i    = do_read;
        resp_i    = 1'($urandom_range(0, 1));
        burst_i   = {$urandom, $urandom};
        @(negedge clk);

        // Cache keeps the request up but its bus contents must not matter now.
        address_i = $urandom;
        line_i    = rand_line();
        while (got_beats < BEATS) begin
            check("req_read_o", read_o, !do_write);
            check("req_write_o", write_o, do_write);
            check("busy_resp_o", resp_o, 1'b0);
            check("address_o", address_o, line_addr(addr));
            if (plen > 0 && cyc < plen) r = pattern[cyc];
            else r = ($urandom_range(0, 99) < 60);
            resp_i  = r;
            burst_i = directed ? {16{4'(got_beats + 1)}} : {$urandom, $urandom};
            if (r) begin
                if (do_write) check("burst_o", burst_o, wline[got_beats*BURST +: BURST]);
                else exp_line[got_beats*BURST +: BURST] = burst_i;
                got_beats++;
            end
            cyc++;
            @(negedge clk);
        end

        // Completion cycle: memory strobe here must be ignored.
        resp_i  = 1'($urandom_range(0, 1));
        burst_i = {$urandom, $urandom};
        check("done_resp_o", resp_o, 1'b1);
        check("done_read_o", read_o, 1'b0);
        check("done_write_o", write_o, 1'b0);
        check("line_o", line_o, exp_line);
        if (!do_write) last_fill = exp_line;
        read_i  = 1'b0;
        write_i = 1'b0;
        @(negedge clk);
        resp_i = 1'b0;
        check("resp_pulse", resp_o, 1'b0);
        check("line_hold", line_o, exp_line);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_o"}, read_o, 1'b0);
        check({tag, "_write_o"}, write_o, 1'b0);
        check({tag, "_resp_o"}, resp_o, 1'b0);
        check({tag, "_line_o"}, line_o, '0);
        check({tag, "_address_o"}, address_o, '0);
        check({tag, "_burst_o"}, burst_o, '0);
    endtask

    initial begin
        rst       = 1'b0;
        address_i = '0;
        line_i    = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Directed fill with recognisable beats, no gaps
        run_txn(1'b0, 1'b1, 32'h1234_5678, rand_line(), 16'hFFFF, 4, 1'b1);
        check("fill_addr_const", address_o, 32'h1234_5660);
        // Writeback, then a read raised the very next cycle
        run_txn(1'b1, 1'b0, 32'h8000_001F, rand_line(), 16'hFFFF, 4, 1'b0);
        check("wb_addr_const", address_o, 32'h8000_0000);
        run_txn(1'b0, 1'b1, $urandom, rand_line(), 16'h0000, 0, 1'b0);
        // Gapped read: strobe pattern 1,0,0,1,1,0,1
        run_txn(1'b0, 1'b1, $urandom, rand_line(), 16'h0059, 7, 1'b0);
        // Simultaneous read and write: write wins
        run_txn(1'b1, 1'b1, $urandom, rand_line(), 16'h0000, 0, 1'b0);

        // Reset in the middle of a fill after two beats
        address_i = 32'hCAFE_0040;
        read_i    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        rst     = 1'b0;
        resp_i  = 1'b0;
        read_i  = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst       = 1'b1;
        last_fill = '0;
        @(negedge clk);
        check("midrst_no_resp", resp_o, 1'b0);
        run_txn(1'b0, 1'b1, $urandom, rand_line(), 16'hFFFF, 4, 1'b0);

        // Random mix of transactions, some with idle cycles between them
        for (int t = 0; t < 40; t++) begin
            bit w;
            bit rd;
            w  = 1'($urandom_range(0, 1));
            rd = w ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(w, rd, $urandom, rand_line(), 16'h0000, 0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                resp_i = 1'b1;
                @(negedge clk);
                resp_i = 1'b0;
                check("idle_gap_resp_o", resp_o, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
